// File: rtl/arbiter_puf_pkg.sv
// rtl/arbiter_puf_pkg.sv - shared state encoding and LFSR constants for the arbiter PUF CRP controller
package arbiter_puf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOW,
    ST_LAUNCH,
    ST_SAMPLE,
    ST_NEXT,
    ST_DONE
  } crp_state_t;

  localparam int          LFSR_W        = 8;
  localparam logic [7:0]  LFSR_TAPS     = 8'hB8;
  localparam logic [7:0]  LFSR_ZERO_SUB = 8'h01;

  // Fibonacci step: feedback is the parity of the tapped bits, shifted in at bit 0.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/crp_lfsr.sv
// rtl/crp_lfsr.sv - seeded 8-bit challenge LFSR (taps 8,6,5,4)
module crp_lfsr
  import arbiter_puf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] state
);

  // An all-zero state would lock the LFSR, so a zero seed is substituted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= '0;
    end else if (load) begin
      state <= (seed == '0) ? LFSR_ZERO_SUB : seed;
    end else if (step) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/arbiter_crp_controller.sv
// rtl/arbiter_crp_controller.sv - arbiter PUF challenge/response sequencer; CRP_MAJORITY_VOTE_EN enables voting
module arbiter_crp_controller
  import arbiter_puf_pkg::*;
#(
  parameter int CH_W       = 8,
  parameter int RESP_BITS  = 32,
  parameter int SETTLE_CYC = 16,
  parameter int VOTE_N     = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [CH_W-1:0]                seed,
  output logic                           busy,
  output logic [CH_W-1:0]                puf_ch,
  output logic                           puf_launch,
  output logic                           puf_rst,
  input  logic                           puf_resp,
  output logic [RESP_BITS-1:0]           resp_word,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [$clog2(RESP_BITS+1)-1:0] unstable_cnt
);

  localparam int BIT_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int TMR_W = $clog2(SETTLE_CYC + 3);
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(RESP_BITS - 1);
  localparam logic [TMR_W-1:0] LOW_END    = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] LAUNCH_END = TMR_W'(SETTLE_CYC + 1);

  if (SETTLE_CYC < 1) begin : g_bad_settle
    $error("SETTLE_CYC must be at least 1");
  end
  if (CH_W != LFSR_W) begin : g_bad_chw
    $error("CH_W must equal the LFSR width");
  end

  crp_state_t       state;
  logic [TMR_W-1:0] timer;
  logic [BIT_W-1:0] bit_cnt;
  logic [1:0]       sync;
  logic             new_bit;

  always_ff @(posedge clk) begin
    if (rst) sync <= '0;
    else     sync <= {sync[0], puf_resp};
  end

  crp_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (state == ST_IDLE && start),
    .step  (state == ST_NEXT),
    .seed  (seed),
    .state (puf_ch)
  );

`ifdef CRP_MAJORITY_VOTE_EN
  localparam int ONES_W = $clog2(VOTE_N + 1);
  localparam logic [ONES_W-1:0] VOTE_L = ONES_W'(VOTE_N);
  localparam logic [ONES_W-1:0] HALF_L = ONES_W'(VOTE_N / 2);

  if (VOTE_N < 3 || (VOTE_N % 2) == 0) begin : g_bad_vote
    $error("VOTE_N must be odd and at least 3");
  end

  logic [ONES_W-1:0]              ones;
  logic [ONES_W-1:0]              eval_cnt;
  logic [$clog2(RESP_BITS+1)-1:0] unstable_q;

  assign new_bit      = ones > HALF_L;
  assign unstable_cnt = unstable_q;
`else
  logic samp_bit;

  assign new_bit      = samp_bit;
  assign unstable_cnt = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      timer      <= '0;
      bit_cnt    <= '0;
      busy       <= 1'b0;
      puf_launch <= 1'b0;
      puf_rst    <= 1'b1;
      resp_valid <= 1'b0;
      resp_word  <= '0;
`ifdef CRP_MAJORITY_VOTE_EN
      ones       <= '0;
      eval_cnt   <= '0;
      unstable_q <= '0;
`else
      samp_bit   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_CLEAR;
            busy      <= 1'b1;
            bit_cnt   <= '0;
            resp_word <= '0;
`ifdef CRP_MAJORITY_VOTE_EN
            ones       <= '0;
            eval_cnt   <= '0;
            unstable_q <= '0;
`endif
          end
        end
        ST_CLEAR: begin
          state   <= ST_LOW;
          puf_rst <= 1'b0;
          timer   <= '0;
        end
        ST_LOW: begin
          if (timer == LOW_END) begin
            state      <= ST_LAUNCH;
            puf_launch <= 1'b1;
            timer      <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        // Two extra cycles let the response cross the synchronizer before sampling.
        ST_LAUNCH: begin
          if (timer == LAUNCH_END) begin
            state      <= ST_SAMPLE;
            puf_launch <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_SAMPLE: begin
`ifdef CRP_MAJORITY_VOTE_EN
          ones     <= ones + ONES_W'(sync[1]);
          eval_cnt <= eval_cnt + 1'b1;
          if (eval_cnt + 1'b1 < VOTE_L) begin
            state   <= ST_CLEAR;
            puf_rst <= 1'b1;
          end else begin
            state <= ST_NEXT;
          end
`else
          samp_bit <= sync[1];
          state    <= ST_NEXT;
`endif
        end
        ST_NEXT: begin
          resp_word <= {new_bit, resp_word[RESP_BITS-1:1]};
          puf_rst   <= 1'b1;
`ifdef CRP_MAJORITY_VOTE_EN
          if (ones != '0 && ones != VOTE_L) unstable_q <= unstable_q + 1'b1;
          ones     <= '0;
          eval_cnt <= '0;
`endif
          if (bit_cnt == LAST_BIT) begin
            state      <= ST_DONE;
            resp_valid <= 1'b1;
          end else begin
            state   <= ST_CLEAR;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (resp_ready) begin
            state      <= ST_IDLE;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
